// File: rtl/pong_game_ctrl.sv
// Per-frame pong sequencer: moves the ball and paddles once per video frame, resolves
// wall/paddle/miss events and keeps score for the renderer.
module pong_game_ctrl #(
  parameter int VIDEO_W      = 640,
  parameter int VIDEO_H      = 480,
  parameter int TOP_Y        = 95,
  parameter int BOT_Y        = 465,
  parameter int P1_X         = 10,
  parameter int P2_X         = 620,
  parameter int PADDLE_W     = 10,
  parameter int PADDLE_H     = 40,
  parameter int BALL_SZ      = 5,
  parameter int BALL_SPEED   = 4,
  parameter int PADDLE_STEP  = 6,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic        iVGA_CLK,
  input  logic        iRST,
  input  logic        iVS,
  input  logic        iStart,
  input  logic        iP1Up,
  input  logic        iP1Dn,
  input  logic        iP2Up,
  input  logic        iP2Dn,
  output logic [10:0] oBallX,
  output logic [9:0]  oBallY,
  output logic [9:0]  oP1Y,
  output logic [9:0]  oP2Y,
  output logic [3:0]  oScore1,
  output logic [3:0]  oScore2,
  output logic [1:0]  oState,
  output logic        oPoint,
  output logic [1:0]  oWinner
);
  typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;

  localparam int BOT_L = (BOT_Y < VIDEO_H) ? BOT_Y : VIDEO_H;
  localparam int CW    = $clog2(SERVE_FRAMES);

  localparam logic signed [11:0] SW   = 12'(VIDEO_W);
  localparam logic signed [11:0] STOP = 12'(TOP_Y);
  localparam logic signed [11:0] SBOT = 12'(BOT_L);
  localparam logic signed [11:0] SP1X = 12'(P1_X);
  localparam logic signed [11:0] SP2X = 12'(P2_X);
  localparam logic signed [11:0] SPW  = 12'(PADDLE_W);
  localparam logic signed [11:0] SPH  = 12'(PADDLE_H);
  localparam logic signed [11:0] SBS  = 12'(BALL_SZ);
  localparam logic signed [11:0] SSPD = 12'(BALL_SPEED);

  localparam logic [10:0] CX    = 11'((VIDEO_W - BALL_SZ) / 2);
  localparam logic [9:0]  CY    = 10'((TOP_Y + BOT_L - BALL_SZ) / 2);
  localparam logic [9:0]  PC    = 10'((TOP_Y + BOT_L - PADDLE_H) / 2);
  localparam logic [9:0]  BTOP  = 10'(TOP_Y);
  localparam logic [9:0]  BBOT  = 10'(BOT_L - BALL_SZ);
  localparam logic [9:0]  PBOT  = 10'(BOT_L - PADDLE_H);
  localparam logic [9:0]  PSTEP = 10'(PADDLE_STEP);
  localparam logic [3:0]  WIN   = 4'(WIN_SCORE);
  localparam logic [CW-1:0] CLAST = CW'(SERVE_FRAMES - 1);

  state_t          state;
  logic            vsQ, vsQ2, tick;
  logic            dxNeg, dyNeg, dyNegNext;
  logic [CW-1:0]   serveCnt;
  logic signed [11:0] nx, ny, p1s, p2s;
  logic [9:0]      yNext, p1Nxt, p2Nxt;
  logic [3:0]      s1Inc, s2Inc;
  logic            hit1, hit2, missL, missR, point;

  function automatic logic [9:0] padNext(input logic [9:0] y, input logic up, input logic dn);
    logic [9:0] r;
    r = y;
    if (up && !dn)      r = (y < BTOP + PSTEP) ? BTOP : y - PSTEP;
    else if (dn && !up) r = (y + PSTEP > PBOT) ? PBOT : y + PSTEP;
    return r;
  endfunction

  assign oState = state;
  assign tick   = vsQ & ~vsQ2;
  assign nx     = $signed({1'b0, oBallX}) + (dxNeg ? -SSPD : SSPD);
  assign ny     = $signed({2'b00, oBallY}) + (dyNeg ? -SSPD : SSPD);
  assign p1s    = $signed({2'b00, oP1Y});
  assign p2s    = $signed({2'b00, oP2Y});
  assign p1Nxt  = padNext(oP1Y, iP1Up, iP1Dn);
  assign p2Nxt  = padNext(oP2Y, iP2Up, iP2Dn);
  assign s1Inc  = oScore1 + 4'd1;
  assign s2Inc  = oScore2 + 4'd1;

  // Paddle tests use the pre-update paddle rows and the unclamped next ball row.
  assign hit1  = dxNeg && (nx <= SP1X + SPW) && (nx + SBS > SP1X)
              && (ny + SBS > p1s) && (ny < p1s + SPH);
  assign hit2  = !dxNeg && (nx + SBS >= SP2X) && (nx < SP2X + SPW)
              && (ny + SBS > p2s) && (ny < p2s + SPH);
  assign missL = (nx <= 12'sd0);
  assign missR = (nx + SBS >= SW);
  assign point = !hit1 && !hit2 && (missL || missR);

  always_comb begin
    yNext     = ny[9:0];
    dyNegNext = dyNeg;
    if (ny <= STOP) begin
      yNext     = BTOP;
      dyNegNext = 1'b0;
    end else if (ny + SBS >= SBOT) begin
      yNext     = BBOT;
      dyNegNext = 1'b1;
    end
  end

  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      state    <= IDLE;
      vsQ      <= 1'b1;
      vsQ2     <= 1'b1;
      oBallX   <= CX;
      oBallY   <= CY;
      oP1Y     <= PC;
      oP2Y     <= PC;
      oScore1  <= '0;
      oScore2  <= '0;
      oPoint   <= 1'b0;
      oWinner  <= 2'd0;
      dxNeg    <= 1'b0;
      dyNeg    <= 1'b0;
      serveCnt <= '0;
    end else begin
      vsQ    <= iVS;
      vsQ2   <= vsQ;
      oPoint <= 1'b0;
      case (state)
        IDLE, OVER: if (iStart) begin
          state    <= SERVE;
          oScore1  <= '0;
          oScore2  <= '0;
          oWinner  <= 2'd0;
          oBallX   <= CX;
          oBallY   <= CY;
          oP1Y     <= PC;
          oP2Y     <= PC;
          dxNeg    <= 1'b0;
          dyNeg    <= 1'b0;
          serveCnt <= '0;
        end
        SERVE: if (tick) begin
          oP1Y <= p1Nxt;
          oP2Y <= p2Nxt;
          if (serveCnt == CLAST) begin
            serveCnt <= '0;
            state    <= PLAY;
          end else begin
            serveCnt <= serveCnt + 1'b1;
          end
        end
        PLAY: if (tick) begin
          oP1Y <= p1Nxt;
          oP2Y <= p2Nxt;
          if (point) begin
            // A winning point freezes the ball where it was; otherwise re-serve toward the loser.
            oPoint <= 1'b1;
            dyNeg  <= dyNegNext;
            if (missL) begin
              oScore2 <= s2Inc;
              if (s2Inc == WIN) begin
                state   <= OVER;
                oWinner <= 2'd2;
              end else begin
                state  <= SERVE;
                dxNeg  <= 1'b1;
                oBallX <= CX;
                oBallY <= CY;
              end
            end else begin
              oScore1 <= s1Inc;
              if (s1Inc == WIN) begin
                state   <= OVER;
                oWinner <= 2'd1;
              end else begin
                state  <= SERVE;
                dxNeg  <= 1'b0;
                oBallX <= CX;
                oBallY <= CY;
              end
            end
          end else begin
            oBallY <= yNext;
            dyNeg  <= dyNegNext;
            if (hit1) begin
              oBallX <= 11'(P1_X + PADDLE_W);
              dxNeg  <= 1'b0;
            end else if (hit2) begin
              oBallX <= 11'(P2_X - BALL_SZ);
              dxNeg  <= 1'b1;
            end else begin
              oBallX <= nx[10:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: stimulus queues expected snapshots and point events,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pong_game_ctrl;
  logic        clk, rst, vs, start, p1u, p1d, p2u, p2d;
  logic [10:0] ballX;
  logic [9:0]  ballY, p1Y, p2Y;
  logic [3:0]  score1, score2;
  logic [1:0]  st, winner;
  logic        pnt;

  int nChk = 0;
  int nFail = 0;

  typedef struct {
    string      name;
    bit         chkBall;
    int         st, bx, by, p1, p2, s1, s2, w;
  } snap_t;
  typedef struct { int s1, s2; } pt_t;

  snap_t snapQ[$];
  pt_t   ptQ[$];

  pong_game_ctrl dut (
    .iVGA_CLK(clk), .iRST(rst), .iVS(vs), .iStart(start),
    .iP1Up(p1u), .iP1Dn(p1d), .iP2Up(p2u), .iP2Dn(p2d),
    .oBallX(ballX), .oBallY(ballY), .oP1Y(p1Y), .oP2Y(p2Y),
    .oScore1(score1), .oScore2(score2), .oState(st),
    .oPoint(pnt), .oWinner(winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int act, input int req);
    nChk++;
    if (act != req) begin
      nFail++;
      $display("FAIL %s got %0d want %0d", nm, act, req);
    end
  endtask

  // Monitor: point pulses are matched against predicted points, snapshots are checked as queued.
  always @(negedge clk) begin
    if (pnt) begin
      if (ptQ.size() == 0) begin
        nChk++;
        nFail++;
        $display("FAIL point.unexpected got oPoint=1 want 0 (s1=%0d s2=%0d)", score1, score2);
      end else begin
        pt_t p;
        p = ptQ.pop_front();
        cmp("point.score1", int'(score1), p.s1);
        cmp("point.score2", int'(score2), p.s2);
      end
    end
    while (snapQ.size() > 0) begin
      snap_t e;
      e = snapQ.pop_front();
      cmp({e.name, ".state"}, int'(st), e.st);
      if (e.chkBall) begin
        cmp({e.name, ".ballX"}, int'(ballX), e.bx);
        cmp({e.name, ".ballY"}, int'(ballY), e.by);
      end
      cmp({e.name, ".p1Y"},    int'(p1Y), e.p1);
      cmp({e.name, ".p2Y"},    int'(p2Y), e.p2);
      cmp({e.name, ".score1"}, int'(score1), e.s1);
      cmp({e.name, ".score2"}, int'(score2), e.s2);
      cmp({e.name, ".winner"}, int'(winner), e.w);
    end
  end

  task automatic chk(input string nm, input bit cb, input int s, input int bx, input int by,
                     input int q1, input int q2, input int s1, input int s2, input int w);
    snap_t e;
    e.name = nm; e.chkBall = cb; e.st = s; e.bx = bx; e.by = by;
    e.p1 = q1; e.p2 = q2; e.s1 = s1; e.s2 = s2; e.w = w;
    snapQ.push_back(e);
  endtask

  task automatic expPoint(input int s1, input int s2);
    pt_t p;
    p.s1 = s1; p.s2 = s2;
    ptQ.push_back(p);
  endtask

  // ctl = {start, p1Up, p1Dn, p2Up, p2Dn}; one frame = one iVS rising edge, returns just after the update edge
  task automatic frames(input int n, input logic [4:0] ctl);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      {start, p1u, p1d, p2u, p2d} = ctl;
      vs = 1'b0;
      @(negedge clk);
      @(negedge clk);
      vs = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; vs = 1'b1; start = 1'b0;
    p1u = 1'b0; p1d = 1'b0; p2u = 1'b0; p2d = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset", 1, 0, 317, 277, 260, 260, 0, 0, 0);

    // Game 1: P1 driven to the top clamp, P2 parked at 308 to meet the ball.
    pulseStart();
    chk("start", 1, 1, 317, 277, 260, 260, 0, 0, 0);
    frames(8, 5'b01001);
    chk("serve8", 1, 1, 317, 277, 212, 308, 0, 0, 0);
    frames(51, 5'b01000);
    chk("serve59", 1, 1, 317, 277, 95, 308, 0, 0, 0);
    frames(1, 5'b01000);
    chk("serve60", 1, 2, 317, 277, 95, 308, 0, 0, 0);
    frames(45, 5'b00000);
    chk("g1k45", 1, 2, 497, 457, 95, 308, 0, 0, 0);
    frames(1, 5'b00000);
    chk("g1botWall", 1, 2, 501, 460, 95, 308, 0, 0, 0);
    frames(1, 5'b00000);
    chk("g1k47", 1, 2, 505, 456, 95, 308, 0, 0, 0);
    frames(27, 5'b00000);
    chk("g1k74", 1, 2, 613, 348, 95, 308, 0, 0, 0);
    frames(1, 5'b00000);
    chk("p2hit", 1, 2, 615, 344, 95, 308, 0, 0, 0);
    frames(1, 5'b00000);
    chk("p2hitNext", 1, 2, 611, 340, 95, 308, 0, 0, 0);
    frames(148, 5'b00000);
    chk("g1k224", 1, 2, 19, 439, 95, 308, 0, 0, 0);
    frames(4, 5'b00000);
    chk("g1k228", 1, 2, 3, 455, 95, 308, 0, 0, 0);
    expPoint(0, 1);
    frames(1, 5'b00000);
    chk("missLeft", 1, 1, 317, 277, 95, 308, 0, 1, 0);
    frames(36, 5'b00100);
    chk("g1serve2", 1, 1, 317, 277, 311, 308, 0, 1, 0);
    frames(24, 5'b00000);
    chk("g1play2", 1, 2, 317, 277, 311, 308, 0, 1, 0);
    frames(46, 5'b00000);
    chk("g1r2k46", 1, 2, 133, 460, 311, 308, 0, 1, 0);
    frames(28, 5'b00000);
    chk("g1r2k74", 1, 2, 21, 348, 311, 308, 0, 1, 0);
    frames(1, 5'b00000);
    chk("p1hit", 1, 2, 20, 344, 311, 308, 0, 1, 0);
    frames(1, 5'b00000);
    chk("p1hitNext", 1, 2, 24, 340, 311, 308, 0, 1, 0);

    // Reset in the middle of play.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("midReset", 1, 0, 317, 277, 260, 260, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Game 2: P2 clamped low so every rally ends in a right-side miss; start held during serve.
    pulseStart();
    frames(5, 5'b11101);
    frames(54, 5'b01101);
    chk("g2serve59", 1, 1, 317, 277, 260, 425, 0, 0, 0);
    frames(1, 5'b01101);
    chk("g2serve60", 1, 2, 317, 277, 260, 425, 0, 0, 0);
    for (int r = 1; r <= 9; r++) begin
      bit odd;
      odd = (r % 2) == 1;
      if (r > 1) begin
        frames(60, 5'b00001);
        chk("g2serve", 1, 2, 317, 277, 260, 425, r - 1, 0, 0);
      end
      frames(45, (r == 2) ? 5'b10001 : 5'b00001);
      chk("g2k45", 1, 2, 497, odd ? 457 : 97, 260, 425, r - 1, 0, 0);
      frames(1, 5'b00001);
      chk("g2wall", 1, 2, 501, odd ? 460 : 95, 260, 425, r - 1, 0, 0);
      frames(1, 5'b00001);
      chk("g2k47", 1, 2, 505, odd ? 456 : 99, 260, 425, r - 1, 0, 0);
      frames(32, 5'b00001);
      chk("g2k79", 1, 2, 633, odd ? 328 : 227, 260, 425, r - 1, 0, 0);
      expPoint(r, 0);
      frames(1, 5'b00001);
      if (r < 9) chk("missRight", 1, 1, 317, 277, 260, 425, r, 0, 0);
      else       chk("win", 0, 3, 0, 0, 260, 425, 9, 0, 1);
    end
    frames(3, 5'b01010);
    chk("overFrozen", 0, 3, 0, 0, 260, 425, 9, 0, 1);
    pulseStart();
    chk("restart", 1, 1, 317, 277, 260, 260, 0, 0, 0);
    frames(1, 5'b00000);
    chk("restartServe", 1, 1, 317, 277, 260, 260, 0, 0, 0);

    repeat (3) @(negedge clk);
    cmp("pointsPending", ptQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end
endmodule
